// File: rtl/instr_encoder_pkg.sv
// Shared instruction-encoding definitions.
//   - RV32I base opcode constants (the common library set)
//   - fmt_e: operand-placement format selected by an opcode
//   - NOP_INSTR: canonical ADDI x0,x0,0 encoding
//   - opcode_fmt(): opcode -> format lookup; unknown opcodes map to FMT_BAD
package instr_encoder_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,      // OP-IMM, LOAD and JALR share the I layout
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e opcode_fmt(input logic [6:0] op);
        case (op)
            OPC_OP:                         return FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: return FMT_I;
            OPC_STORE:                      return FMT_S;
            OPC_BRANCH:                     return FMT_B;
            OPC_JAL:                        return FMT_J;
            OPC_LUI, OPC_AUIPC:             return FMT_U;
            default:                        return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational RV32I field packer and immediate legality check.
// Ports:
//   op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i  decoded instruction fields
//   imm_i      immediate in the zero-extended decoder output form
//   word_o     packed instruction word (unused fields are zero)
//   illegal_o  1 when the opcode is unknown or imm_i cannot be represented
// The legality rules mirror the immediate generator exactly: any bit that
// the generator would not reproduce from the packed word must be zero.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [6:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (opcode_fmt(op_i))
            FMT_R: begin
                word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
            end
            FMT_I: begin
                word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
                illegal_o = |imm_i[31:12];
            end
            FMT_S: begin
                word_o    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
                illegal_o = |imm_i[31:12];
            end
            FMT_B: begin
                // Branch offsets are even; bit 0 is not encodable.
                word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], op_i};
                illegal_o = (|imm_i[31:13]) | imm_i[0];
            end
            FMT_J: begin
                word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
                illegal_o = (|imm_i[31:21]) | imm_i[0];
            end
            FMT_U: begin
                word_o    = {imm_i[31:12], rd_i, op_i};
                illegal_o = |imm_i[11:0];
            end
            default: begin
                // Never emitted: the illegal flag causes the entry to be dropped.
                word_o    = NOP_INSTR;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into RV32I words and emits
// them with sequential word-aligned write addresses through a two-stage
// valid/ready pipeline (s1 = packed word + illegal flag, s2 = output reg).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          request handshake
//   in_opcode..in_imm          decoded fields
//   out_valid/out_ready        output handshake
//   out_instr, out_addr        encoded word and its write address
//   err_pulse                  high while an illegal s1 entry is being dropped
//   err_count                  saturating count of dropped requests
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_addr,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [31:0]          pack_word;
    logic                 pack_illegal;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_illegal_q, s1_illegal_d;
    logic [31:0]          s1_word_q, s1_word_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          s2_instr_q, s2_instr_d;
    logic [31:0]          addr_q, addr_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic                 s1_advance;
    logic                 in_fire;
    logic                 out_fire;
    logic                 s1_drop;

    instr_pack u_pack (
        .op_i      (in_opcode),
        .rd_i      (in_rd),
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .funct3_i  (in_funct3),
        .funct7_i  (in_funct7),
        .imm_i     (in_imm),
        .word_o    (pack_word),
        .illegal_o (pack_illegal)
    );

    // An illegal entry never needs s2, so it drains regardless of backpressure.
    assign s1_advance = s1_valid_q && (s1_illegal_q || !s2_valid_q || out_ready);
    assign in_ready   = !s1_valid_q || s1_advance;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = s2_valid_q && out_ready;
    assign s1_drop    = s1_valid_q && s1_illegal_q;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_illegal_d = s1_illegal_q;
        s1_word_d    = s1_word_q;
        if (in_fire) begin
            s1_valid_d   = 1'b1;
            s1_illegal_d = pack_illegal;
            s1_word_d    = pack_word;
        end else if (s1_advance) begin
            s1_valid_d   = 1'b0;
        end
    end

    // s2 may hand off its word and take the next one on the same edge.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        if (s1_advance && !s1_illegal_q) begin
            s2_valid_d = 1'b1;
            s2_instr_d = s1_word_q;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        addr_d      = out_fire ? addr_q + 32'd4 : addr_q;
        err_count_d = err_count_q;
        if (s1_drop && !(&err_count_q)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_illegal_q <= 1'b0;
            s1_word_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_instr_q   <= '0;
            addr_q       <= START_ADDR;
            err_count_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_illegal_q <= s1_illegal_d;
            s1_word_q    <= s1_word_d;
            s2_valid_q   <= s2_valid_d;
            s2_instr_q   <= s2_instr_d;
            addr_q       <= addr_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_addr  = addr_q;
    assign err_pulse = s1_drop;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed vector table, backpressure, illegal
// drain under stall, address wrap, error-counter saturation, reset mid-flight
// and a random legal-request round trip through an independent immediate
// generator (zero-extended decoder form).
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam logic [31:0] W_START = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_instr, out_addr;
    logic        err_pulse;
    logic [7:0]  err_count;

    logic        w_in_valid = 1'b0, w_in_ready;
    logic        w_out_valid, w_out_ready = 1'b1;
    logic [31:0] w_out_instr, w_out_addr;
    logic        w_err_pulse;
    logic [1:0]  w_err_count;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    instr_encoder #(.START_ADDR(32'h0000_0000), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_pulse(err_pulse), .err_count(err_count)
    );

    // Second instance: wrap-around start address and a 2-bit error counter.
    instr_encoder #(.START_ADDR(W_START), .ERR_CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr),
        .out_addr(w_out_addr), .err_pulse(w_err_pulse), .err_count(w_err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_opcode = v.op;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_imm    = v.imm;
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input logic [31:0] word,
                                input logic ill);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.word = word; v.ill = ill;
        return v;
    endfunction

    // Independent immediate generator (zero-extending decoder form).
    function automatic logic [31:0] imm_gen(input logic [31:0] w);
        case (w[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: return {20'b0, w[31:20]};
            OPC_STORE:  return {20'b0, w[31:25], w[11:7]};
            OPC_BRANCH: return {19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0};
            OPC_JAL:    return {11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0};
            OPC_LUI, OPC_AUIPC: return {w[31:12], 12'b0};
            default:    return 32'b0;
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [18];
        logic [31:0] exp_addr;
        logic [31:0] exp_errs;
        logic [6:0]  ops [9];

        vecs[0]  = mk(OPC_JAL,    5'd1,  5'd0, 5'd0, 3'd0, 7'd0,    32'h0000_0001, 32'h0, 1'b1);
        vecs[1]  = mk(OPC_STORE,  5'd0,  5'd2, 5'd3, 3'd2, 7'd0,    32'h0000_1000, 32'h0, 1'b1);
        vecs[2]  = mk(OPC_LUI,    5'd5,  5'd0, 5'd0, 3'd0, 7'd0,    32'h1234_5000, 32'h1234_52B7, 1'b0);
        vecs[3]  = mk(OPC_OP_IMM, 5'd1,  5'd0, 5'd0, 3'd0, 7'h7F,   32'h0000_07FF, 32'h7FF0_0093, 1'b0);
        vecs[4]  = mk(OPC_BRANCH, 5'd0,  5'd1, 5'd2, 3'd0, 7'd0,    32'h0000_0800, 32'h0020_80E3, 1'b0);
        vecs[5]  = mk(OPC_BRANCH, 5'd0,  5'd1, 5'd2, 3'd0, 7'd0,    32'h0000_0008, 32'h0020_8463, 1'b0);
        vecs[6]  = mk(OPC_STORE,  5'd9,  5'd2, 5'd3, 3'd2, 7'd0,    32'h0000_07FC, 32'h7E31_2E23, 1'b0);
        vecs[7]  = mk(OPC_JAL,    5'd1,  5'd0, 5'd0, 3'd0, 7'd0,    32'h0000_0800, 32'h0010_00EF, 1'b0);
        vecs[8]  = mk(OPC_JAL,    5'd0,  5'd0, 5'd0, 3'd0, 7'd0,    32'h001F_FFFE, 32'hFFFF_F06F, 1'b0);
        vecs[9]  = mk(OPC_OP,     5'd3,  5'd4, 5'd5, 3'd0, 7'h20,   32'hDEAD_BEEF, 32'h4052_01B3, 1'b0);
        vecs[10] = mk(OPC_JALR,   5'd1,  5'd2, 5'd0, 3'd0, 7'd0,    32'h0000_0004, 32'h0041_00E7, 1'b0);
        vecs[11] = mk(OPC_LOAD,   5'd6,  5'd7, 5'd0, 3'd2, 7'd0,    32'h0000_0FFF, 32'hFFF3_A303, 1'b0);
        vecs[12] = mk(OPC_AUIPC,  5'd31, 5'd0, 5'd0, 3'd0, 7'd0,    32'hFFFF_F000, 32'hFFFF_FF97, 1'b0);
        vecs[13] = mk(7'h7F,      5'd1,  5'd1, 5'd1, 3'd0, 7'd0,    32'h0000_0000, 32'h0, 1'b1);
        vecs[14] = mk(OPC_BRANCH, 5'd0,  5'd0, 5'd0, 3'd1, 7'd0,    32'h0000_1FFE, 32'hFE00_1FE3, 1'b0);
        vecs[15] = mk(OPC_LUI,    5'd2,  5'd0, 5'd0, 3'd0, 7'd0,    32'h0000_0001, 32'h0, 1'b1);
        vecs[16] = mk(OPC_BRANCH, 5'd0,  5'd1, 5'd1, 3'd0, 7'd0,    32'h0000_0003, 32'h0, 1'b1);
        vecs[17] = mk(OPC_OP_IMM, 5'd1,  5'd1, 5'd0, 3'd0, 7'd0,    32'h0000_1000, 32'h0, 1'b1);

        ops[0] = OPC_LUI;  ops[1] = OPC_AUIPC;  ops[2] = OPC_JAL;
        ops[3] = OPC_JALR; ops[4] = OPC_BRANCH; ops[5] = OPC_LOAD;
        ops[6] = OPC_STORE; ops[7] = OPC_OP_IMM; ops[8] = OPC_OP;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_out_addr",  out_addr,       32'h0);
        chk("rst_out_instr", out_instr,      32'h0);
        chk("rst_w_addr",    w_out_addr,     W_START);

        // ---- directed vector table, one request at a time ----
        exp_addr = 32'h0;
        exp_errs = 32'd0;
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            chk("vec_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("vec_err_pulse", 32'(err_pulse), 32'(vecs[i].ill));
            chk("vec_latency",   32'(out_valid), 32'd0);
            @(posedge clk); #1;
            if (vecs[i].ill) begin
                exp_errs++;
                chk("vec_dropped", 32'(out_valid), 32'd0);
                chk("vec_addr_kept", out_addr, exp_addr);
            end else begin
                chk("vec_out_valid", 32'(out_valid), 32'd1);
                chk("vec_word", out_instr, vecs[i].word);
                chk("vec_addr", out_addr, exp_addr);
                @(posedge clk); #1;
                exp_addr = exp_addr + 32'd4;
                chk("vec_drained", 32'(out_valid), 32'd0);
            end
            chk("vec_err_count", 32'(err_count), exp_errs);
            $display("vec %0d op=%02h imm=%08h -> word=%08h addr=%08h errs=%0d",
                     i, vecs[i].op, vecs[i].imm, out_instr, out_addr, err_count);
        end

        // ---- backpressure: out_ready low for 5 cycles, 4 requests offered ----
        begin
            int k = 0, got = 0;
            logic [31:0] held = '0;
            logic seen = 1'b0;
            for (int c = 0; c < 40 && got < 4; c++) begin
                out_ready = (c >= 5);
                if (k < 4) begin
                    drive(vecs[6 + k]);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
                if (c < 5 && out_valid) begin
                    if (!seen) begin
                        held = out_instr;
                        seen = 1'b1;
                        chk("bp_first_word", out_instr, vecs[6].word);
                    end else begin
                        chk("bp_stable_word", out_instr, held);
                    end
                    chk("bp_stable_addr", out_addr, exp_addr);
                end
                if (out_valid && out_ready) begin
                    chk("bp_word", out_instr, vecs[6 + got].word);
                    chk("bp_addr", out_addr, exp_addr);
                    $display("bp out word=%08h addr=%08h", out_instr, out_addr);
                    got++;
                    exp_addr = exp_addr + 32'd4;
                end
                if (in_valid && in_ready) k++;
                if (c == 4) chk("bp_accepted", 32'(k), 32'd2);
                @(posedge clk); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("bp_all_out", 32'(got), 32'd4);
        end

        // ---- address wrap and error saturation on the second instance ----
        begin
            int wk = 0, wg = 0;
            logic [31:0] wa = W_START;
            vec_t wv [3];
            wv[0] = vecs[2]; wv[1] = vecs[3]; wv[2] = vecs[10];
            for (int c = 0; c < 20 && wg < 3; c++) begin
                if (wk < 3) begin
                    drive(wv[wk]);
                    w_in_valid = 1'b1;
                end else begin
                    w_in_valid = 1'b0;
                end
                @(negedge clk);
                if (w_out_valid && w_out_ready) begin
                    chk("wrap_word", w_out_instr, wv[wg].word);
                    chk("wrap_addr", w_out_addr, wa);
                    $display("wrap out word=%08h addr=%08h", w_out_instr, w_out_addr);
                    wa = wa + 32'd4;
                    wg++;
                end
                if (w_in_valid && w_in_ready) wk++;
                @(posedge clk); #1;
            end
            w_in_valid = 1'b0;
            chk("wrap_count", 32'(wg), 32'd3);
            chk("wrap_final_addr", w_out_addr, 32'h0000_0004);

            wk = 0;
            drive(vecs[0]);
            for (int c = 0; c < 20 && wk < 5; c++) begin
                w_in_valid = 1'b1;
                @(negedge clk);
                if (w_in_valid && w_in_ready) wk++;
                @(posedge clk); #1;
            end
            w_in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("sat_err_count", 32'(w_err_count), 32'd3);
            chk("sat_addr_kept", w_out_addr, 32'h0000_0004);
            chk("sat_no_output", 32'(w_out_valid), 32'd0);
        end

        // ---- random legal requests: round trip through the immediate generator ----
        begin
            logic [31:0] q_imm [$];
            logic [6:0]  q_op  [$];
            logic [31:0] e_imm;
            logic [6:0]  e_op;
            int sent = 0, rcv = 0;
            bit have = 1'b0;
            for (int c = 0; c < 40000 && rcv < 10000; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (sent < 10000) begin
                    if (!have) begin
                        in_opcode = ops[$urandom_range(0, 8)];
                        in_rd     = 5'($urandom_range(0, 31));
                        in_rs1    = 5'($urandom_range(0, 31));
                        in_rs2    = 5'($urandom_range(0, 31));
                        in_funct3 = 3'($urandom_range(0, 7));
                        in_funct7 = 7'($urandom_range(0, 127));
                        case (in_opcode)
                            OPC_LUI, OPC_AUIPC: in_imm = $urandom & 32'hFFFF_F000;
                            OPC_JAL:            in_imm = $urandom & 32'h001F_FFFE;
                            OPC_BRANCH:         in_imm = $urandom & 32'h0000_1FFE;
                            OPC_OP:             in_imm = $urandom;
                            default:            in_imm = $urandom & 32'h0000_0FFF;
                        endcase
                        have = 1'b1;
                    end
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
                if (in_valid && in_ready) begin
                    q_op.push_back(in_opcode);
                    q_imm.push_back(in_opcode == OPC_OP ? 32'h0 : in_imm);
                    sent++;
                    have = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (q_imm.size() == 0) begin
                        chk("rt_unexpected_word", 32'(q_imm.size()), 32'd1);
                    end else begin
                        e_imm = q_imm.pop_front();
                        e_op  = q_op.pop_front();
                        chk("rt_imm", imm_gen(out_instr), e_imm);
                        chk("rt_op",  32'(out_instr[6:0]), 32'(e_op));
                        chk("rt_addr", out_addr, exp_addr);
                    end
                    exp_addr = exp_addr + 32'd4;
                    rcv++;
                end
                @(posedge clk); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("rt_all_out", 32'(rcv), 32'd10000);
            chk("rt_no_errors", 32'(err_count), exp_errs);
            $display("random stream: %0d words, final addr=%08h", rcv, out_addr);
        end

        // ---- illegal drains under stall, then reset with entries in flight ----
        out_ready = 1'b0;
        drive(vecs[2]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(vecs[0]);
        @(posedge clk); #1;
        chk("stall_s2_valid",     32'(out_valid), 32'd1);
        chk("stall_s2_word",      out_instr, vecs[2].word);
        chk("stall_ill_pulse",    32'(err_pulse), 32'd1);
        chk("stall_ill_in_ready", 32'(in_ready), 32'd1);
        drive(vecs[3]);
        @(posedge clk); #1;
        exp_errs++;
        chk("stall_err_count", 32'(err_count), exp_errs);
        chk("stall_pulse_end", 32'(err_pulse), 32'd0);
        chk("stall_full",      32'(in_ready), 32'd0);
        chk("stall_word_hold", out_instr, vecs[2].word);
        chk("stall_addr_hold", out_addr, exp_addr);
        $display("stall: word=%08h addr=%08h errs=%0d", out_instr, out_addr, err_count);

        drive(vecs[0]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_addr",      out_addr, 32'h0);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
        chk("mid_rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("mid_rst_instr",     out_instr, 32'h0);
        chk("mid_rst_in_ready",  32'(in_ready), 32'd1);
        chk("mid_rst_w_addr",    w_out_addr, W_START);

        drive(vecs[3]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_word",  out_instr, vecs[3].word);
        chk("post_rst_addr",  out_addr, 32'h0);
        $display("post reset word=%08h addr=%08h", out_instr, out_addr);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
